// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, memory access types and arbiter state encoding
package mem_arbiter_pkg;

  localparam int DataBusBits    = 64;
  localparam int InstrBusBits   = 32;
  localparam int MemTypeBusBits = 3;
  localparam int ArbStateBits   = 2;

  localparam logic [MemTypeBusBits-1:0] MemTypeByte   = 3'd0;
  localparam logic [MemTypeBusBits-1:0] MemTypeHalf   = 3'd1;
  localparam logic [MemTypeBusBits-1:0] MemTypeWord   = 3'd2;
  localparam logic [MemTypeBusBits-1:0] MemTypeDouble = 3'd3;

  typedef enum logic [ArbStateBits-1:0] {
    ArbIdle   = 2'd0,
    ArbIFetch = 2'd1,
    ArbData   = 2'd2
  } arbStateT;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// rtl/mem_arbiter_starve_counter.sv - saturating count of data grants made while fetch waits
module arb_starve_counter #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MaxCount = W'(LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MaxCount)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and data requesters
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DataBusBits,
  parameter int DATA_W       = DataBusBits,
  parameter int INSTR_W      = InstrBusBits,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req,
  input  logic [ADDR_W-1:0]         i_addr,
  output logic                      i_ready,
  output logic [INSTR_W-1:0]        i_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [MemTypeBusBits-1:0] d_type,
  input  logic [ADDR_W-1:0]         d_addr,
  input  logic [DATA_W-1:0]         d_wdata,
  output logic                      d_ready,
  output logic [DATA_W-1:0]         d_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MemTypeBusBits-1:0] mem_type,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      stall
);

  localparam int CntW = $clog2(STARVE_LIMIT + 1);

  arbStateT        state;
  logic            abortFlag;
  logic [CntW-1:0] starveCnt;
  logic            fetchStarved;
  logic            grantData;
  logic            grantFetch;

  assign fetchStarved = (starveCnt == CntW'(STARVE_LIMIT));

  // Data wins ties unless fetch has already lost STARVE_LIMIT times in a row.
  always_comb begin
    grantData  = 1'b0;
    grantFetch = 1'b0;
    if (state == ArbIdle) begin
      if (d_req && !(i_req && fetchStarved)) begin
        grantData = 1'b1;
      end else if (i_req) begin
        grantFetch = 1'b1;
      end
    end
  end

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT),
    .W    (CntW)
  ) starveCounter (
    .clk  (clk),
    .reset(reset),
    .inc  (grantData & i_req),
    .clear(grantFetch),
    .count(starveCnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ArbIdle;
      abortFlag <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_type  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        ArbIdle: begin
          if (grantData) begin
            state     <= ArbData;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_type  <= d_type;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grantFetch) begin
            state     <= ArbIFetch;
            abortFlag <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_type  <= MemTypeWord;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
          end
        end
        ArbIFetch: begin
          // A flushed fetch still has to drain its memory transaction.
          if (mem_ack) begin
            state     <= ArbIdle;
            mem_req   <= 1'b0;
            abortFlag <= 1'b0;
            if (!abortFlag && i_req) begin
              i_ready <= 1'b1;
              i_rdata <= mem_rdata[INSTR_W-1:0];
            end
          end else if (!i_req) begin
            abortFlag <= 1'b1;
          end
        end
        ArbData: begin
          if (mem_ack) begin
            state   <= ArbIdle;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        default: state <= ArbIdle;
      endcase
    end
  end

  assign stall = ~reset & ((i_req & ~i_ready) | (d_req & ~d_ready));

  dataReqHeld: assert property (@(posedge clk) disable iff (reset)
    (state == ArbData) |-> (d_req && (d_we == mem_we) && (d_type == mem_type) &&
                            (d_addr == mem_addr) && (d_wdata == mem_wdata)));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int IW    = 32;
  localparam int LIMIT = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      i_req;
  logic [AW-1:0]             i_addr;
  logic                      i_ready;
  logic [IW-1:0]             i_rdata;
  logic                      d_req;
  logic                      d_we;
  logic [MemTypeBusBits-1:0] d_type;
  logic [AW-1:0]             d_addr;
  logic [DW-1:0]             d_wdata;
  logic                      d_ready;
  logic [DW-1:0]             d_rdata;
  logic                      mem_req;
  logic                      mem_we;
  logic [MemTypeBusBits-1:0] mem_type;
  logic [AW-1:0]             mem_addr;
  logic [DW-1:0]             mem_wdata;
  logic                      mem_ack;
  logic [DW-1:0]             mem_rdata;
  logic                      stall;

  int          checks = 0;
  int          errors = 0;
  int          latency = 0;
  int          waitLeft = 0;
  bit          respEnable = 0;
  bit          memActive = 0;
  bit          ackNow = 0;
  logic [DW-1:0] lastAck = '0;
  logic [IW-1:0] expIrdata = '0;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  // Advance one cycle, then act as memory: ack after `latency` waiting cycles of mem_req.
  task automatic tick();
    @(posedge clk);
    #1;
    ackNow = 1'b0;
    if (respEnable) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!memActive) begin
          memActive = 1'b1;
          waitLeft  = latency;
        end
        if (waitLeft == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = {$urandom, $urandom};
          lastAck   = mem_rdata;
          ackNow    = 1'b1;
          memActive = 1'b0;
        end else begin
          waitLeft--;
        end
      end else begin
        memActive = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_type = MemTypeWord;
    i_addr = 64'h40; d_addr = 64'h80; d_wdata = '1; mem_ack = 1'b1; mem_rdata = '1;
    respEnable = 1'b0;
    repeat (2) tick();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++;
    if ({mem_we, mem_type, mem_addr, mem_wdata, i_ready, d_ready, i_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b type=%0d addr=%h wdata=%h ir=%b dr=%b irdata=%h drdata=%h want all 0",
               mem_we, mem_type, mem_addr, mem_wdata, i_ready, d_ready, i_rdata, d_rdata);
    end
    i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0; reset = 1'b0;
    respEnable = 1'b1; memActive = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_release: got mem_req=%b stall=%b want 0 0", mem_req, stall);
    end
  endtask

  task automatic test_fetch();
    bit seen = 0;
    bit done = 0;
    logic [DW-1:0] ack = '0;
    latency = 2; i_addr = 64'h100; i_req = 1'b1;
    for (int t = 1; t <= 20 && !done; t++) begin
      tick();
      if (ackNow) ack = lastAck;
      if (mem_req && !seen) begin
        seen = 1;
        checks++;
        if (mem_addr !== 64'h100 || mem_we !== 1'b0 || mem_type !== MemTypeWord || mem_wdata !== '0) begin
          errors++;
          $display("FAIL fetch_fields: got addr=%h we=%b type=%0d wdata=%h want addr=100 we=0 type=%0d wdata=0",
                   mem_addr, mem_we, mem_type, mem_wdata, MemTypeWord);
        end
      end
      if (i_ready) begin
        checks++;
        if (i_rdata !== ack[IW-1:0]) begin errors++; $display("FAIL fetch_rdata: got %h want %h", i_rdata, ack[IW-1:0]); end
        checks++;
        if (t != latency + 2) begin errors++; $display("FAIL fetch_latency: got %0d want %0d", t, latency + 2); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_release: got %b want 0", stall); end
        expIrdata = ack[IW-1:0];
        i_req = 1'b0; done = 1;
      end else begin
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall: got %b want 1 at cycle %0d", stall, t); end
      end
    end
    if (!done) begin checks++; errors++; $display("FAIL fetch_timeout: got no i_ready want one pulse"); end
    tick();
    checks++;
    if (i_ready !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL fetch_after: got ir=%b mem_req=%b stall=%b want 0 0 0", i_ready, mem_req, stall);
    end
  endtask

  task automatic test_starvation();
    int cnt = 0;
    int grants = 0;
    bit prevReq = 0;
    bit isI;
    bit expI;
    bit done = 0;
    logic [DW-1:0] ack = '0;
    latency = 1; i_addr = 64'h4000; d_addr = 64'h8000; d_we = 1'b0; d_type = MemTypeDouble;
    d_wdata = '0; i_req = 1'b1; d_req = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      tick();
      if (ackNow) ack = lastAck;
      if (i_ready) expIrdata = ack[IW-1:0];
      if (mem_req && !prevReq && grants < 10) begin
        isI  = (mem_addr == 64'h4000);
        expI = (cnt == LIMIT);
        cnt  = expI ? 0 : ((cnt < LIMIT) ? cnt + 1 : LIMIT);
        grants++;
        checks++;
        if (isI !== expI) begin
          errors++;
          $display("FAIL starve_grant%0d: got %s want %s", grants, isI ? "I" : "D", expI ? "I" : "D");
        end
      end
      prevReq = mem_req;
      if (grants == 10 && (i_ready || d_ready)) begin
        i_req = 1'b0; d_req = 1'b0; done = 1;
      end
    end
    if (!done) begin checks++; errors++; $display("FAIL starve_timeout: got %0d grants want 10", grants); end
    tick();
  endtask

  task automatic test_store();
    logic [DW-1:0] ack = '0;
    logic [DW-1:0] loadVal = '0;
    bit done;
    for (int k = 0; k < 2; k++) begin
      done = 0;
      latency = 3;
      d_we    = (k == 1);
      d_addr  = (k == 1) ? 64'h2008 : 64'h2000;
      d_wdata = (k == 1) ? 64'hDEADBEEF : 64'h0;
      d_type  = (k == 1) ? MemTypeWord : MemTypeDouble;
      d_req   = 1'b1;
      for (int t = 1; t <= 20 && !done; t++) begin
        tick();
        if (ackNow) ack = lastAck;
        if (mem_req) begin
          checks++;
          if (mem_we !== d_we || mem_addr !== d_addr || mem_wdata !== d_wdata || mem_type !== d_type) begin
            errors++;
            $display("FAIL data_fields%0d: got we=%b addr=%h wdata=%h type=%0d want we=%b addr=%h wdata=%h type=%0d",
                     k, mem_we, mem_addr, mem_wdata, mem_type, d_we, d_addr, d_wdata, d_type);
          end
        end
        if (d_ready) begin
          if (k == 0) loadVal = ack;
          checks++;
          if (d_rdata !== loadVal) begin errors++; $display("FAIL data_rdata%0d: got %h want %h", k, d_rdata, loadVal); end
          checks++;
          if (t != latency + 2) begin errors++; $display("FAIL data_latency%0d: got %0d want %0d", k, t, latency + 2); end
          d_req = 1'b0; done = 1;
        end
      end
      if (!done) begin checks++; errors++; $display("FAIL data_timeout%0d: got no d_ready want one pulse", k); end
      tick();
      checks++;
      if (d_ready !== 1'b0) begin errors++; $display("FAIL data_pulse%0d: got d_ready=%b want 0", k, d_ready); end
    end
  endtask

  task automatic test_abort();
    logic [IW-1:0] keep;
    logic [DW-1:0] ack = '0;
    int pulses = 0;
    bit done = 0;
    keep = expIrdata;
    latency = 4; i_addr = 64'h300; i_req = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_grant: got mem_req=%b want 1", mem_req); end
    tick();
    i_req = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (i_ready) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL abort_ready: got %0d pulses want 0", pulses); end
    checks++;
    if (i_rdata !== keep) begin errors++; $display("FAIL abort_rdata: got %h want %h", i_rdata, keep); end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL abort_idle: got mem_req=%b want 0", mem_req); end
    latency = 0; i_addr = 64'h304; i_req = 1'b1;
    for (int t = 0; t < 10 && !done; t++) begin
      tick();
      if (ackNow) ack = lastAck;
      if (i_ready) begin
        checks++;
        if (i_rdata !== ack[IW-1:0] || mem_addr !== 64'h304) begin
          errors++; $display("FAIL abort_refetch: got rdata=%h addr=%h want rdata=%h addr=304", i_rdata, mem_addr, ack[IW-1:0]);
        end
        expIrdata = ack[IW-1:0];
        i_req = 1'b0; done = 1;
      end
    end
    if (!done) begin checks++; errors++; $display("FAIL abort_refetch_timeout: got no i_ready want one pulse"); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    latency = 1000;
    d_we = 1'b0; d_type = MemTypeDouble; d_addr = 64'h6000; d_wdata = '0; d_req = 1'b1;
    for (int t = 0; t < 10 && !seen; t++) begin
      tick();
      seen = mem_req;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_grant: got mem_req=0 want 1"); end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_async: got mem_req=%b want 0", mem_req); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", stall); end
    d_req = 1'b0;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_type, mem_addr, mem_wdata, i_ready, d_ready, i_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got req=%b addr=%h dr=%b drdata=%h want all 0", mem_req, mem_addr, d_ready, d_rdata);
    end
    respEnable = 1'b0; reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    mem_ack = 1'b0;
    tick();
    checks++;
    if (d_ready !== 1'b0 || i_ready !== 1'b0 || mem_req !== 1'b0 || d_rdata !== '0) begin
      errors++; $display("FAIL rstmid_stray_ack: got dr=%b ir=%b req=%b drdata=%h want 0 0 0 0", d_ready, i_ready, mem_req, d_rdata);
    end
    respEnable = 1'b1; memActive = 1'b0;
  endtask

  task automatic test_random();
    int cnt = 0;
    bit idle = 1;
    bit ackPrev = 0;
    bit ownerD = 0;
    bit ownerWe = 0;
    bit expIr;
    bit expDr;
    logic [DW-1:0] ackData = '0;
    logic [DW-1:0] expD = '0;
    logic [IW-1:0] expI = '0;
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0; memActive = 1'b0;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (n >= 400 && idle && !i_req && !d_req) break;
      latency = $urandom_range(0, 3);
      tick();
      expIr = 0; expDr = 0;
      if (idle) begin
        if (i_req || d_req) begin
          ownerD = d_req && !(i_req && cnt == LIMIT);
          checks++;
          if (ownerD) begin
            if (mem_req !== 1'b1 || mem_addr !== d_addr || mem_we !== d_we || mem_type !== d_type || mem_wdata !== d_wdata) begin
              errors++;
              $display("FAIL rand_grant_data n=%0d: got req=%b addr=%h we=%b want req=1 addr=%h we=%b", n, mem_req, mem_addr, mem_we, d_addr, d_we);
            end
            if (i_req && cnt < LIMIT) cnt++;
            ownerWe = d_we;
          end else begin
            if (mem_req !== 1'b1 || mem_addr !== i_addr || mem_we !== 1'b0 || mem_type !== MemTypeWord || mem_wdata !== '0) begin
              errors++;
              $display("FAIL rand_grant_fetch n=%0d: got req=%b addr=%h we=%b want req=1 addr=%h we=0", n, mem_req, mem_addr, mem_we, i_addr);
            end
            cnt = 0;
          end
          idle = 0;
        end else begin
          checks++;
          if (mem_req !== 1'b0) begin errors++; $display("FAIL rand_idle n=%0d: got mem_req=%b want 0", n, mem_req); end
        end
      end else if (ackPrev) begin
        idle = 1;
        if (ownerD) begin
          expDr = 1;
          if (!ownerWe) expD = ackData;
        end else begin
          expIr = 1;
          expI  = ackData[IW-1:0];
        end
        checks++;
        if (mem_req !== 1'b0 || i_rdata !== expI || d_rdata !== expD) begin
          errors++;
          $display("FAIL rand_complete n=%0d: got req=%b irdata=%h drdata=%h want req=0 irdata=%h drdata=%h", n, mem_req, i_rdata, d_rdata, expI, expD);
        end
      end else begin
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rand_hold n=%0d: got mem_req=%b want 1", n, mem_req); end
      end
      checks++;
      if ({i_ready, d_ready} !== {expIr, expDr}) begin
        errors++; $display("FAIL rand_ready n=%0d: got ir=%b dr=%b want ir=%b dr=%b", n, i_ready, d_ready, expIr, expDr);
      end
      checks++;
      if (stall !== ((i_req && !expIr) || (d_req && !expDr))) begin
        errors++; $display("FAIL rand_stall n=%0d: got %b want %b", n, stall, (i_req && !expIr) || (d_req && !expDr));
      end
      ackPrev = ackNow;
      if (ackNow) ackData = lastAck;
      if (expDr || !d_req) begin
        if (n < 400 && $urandom_range(0, 2) == 0) begin
          d_req   = 1'b1;
          d_we    = $urandom_range(0, 1) == 1;
          d_type  = MemTypeBusBits'($urandom_range(0, 7));
          d_addr  = 64'h8000 + 64'($urandom_range(0, 1023)) * 8;
          d_wdata = {$urandom, $urandom};
        end else begin
          d_req = 1'b0;
        end
      end
      if (expIr || !i_req) begin
        if (n < 400 && $urandom_range(0, 2) == 0) begin
          i_req  = 1'b1;
          i_addr = 64'h1000 + 64'($urandom_range(0, 1023)) * 4;
        end else begin
          i_req = 1'b0;
        end
      end
    end
    checks++;
    if (!idle || i_req || d_req) begin
      errors++; $display("FAIL rand_drain: got idle=%b i_req=%b d_req=%b want 1 0 0", idle, i_req, d_req);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_starvation();
    test_store();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
